led_scan_ctrl: RTL

Controller for the 8-LED bar on the Red Pitaya board. It generates the step timing and sequences the bar through OFF / SCAN (bouncing lit segment) / BLINK / STATIC modes. It also grants the bar to an external override requester through a req/ack handshake. It sits between the register/config logic and the led_out pins.

---
 rtl/led_ctrl_pkg.sv | 45 ++++
 rtl/led_step_prescaler.sv | 45 ++++
 rtl/led_scan_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared encodings and helpers for the LED bar controller.
package led_ctrl_pkg;

   localparam int          NUM_LEDS = 8;
   localparam int unsigned DIV_10HZ = 32'd12_499_999;

   localparam logic [1:0] MODE_OFF    = 2'd0;
   localparam logic [1:0] MODE_SCAN   = 2'd1;
   localparam logic [1:0] MODE_BLINK  = 2'd2;
   localparam logic [1:0] MODE_STATIC = 2'd3;

   typedef enum logic [2:0] {
      S_OFF    = 3'd0,
      S_SCAN   = 3'd1,
      S_BLINK  = 3'd2,
      S_STATIC = 3'd3,
      S_OVR    = 3'd4
   } state_t;

   function automatic state_t mode_to_state(input logic [1:0] mode);
      state_t st;
      case (mode)
         MODE_OFF:    st = S_OFF;
         MODE_SCAN:   st = S_SCAN;
         MODE_BLINK:  st = S_BLINK;
         MODE_STATIC: st = S_STATIC;
         default:     st = S_OFF;
      endcase
      return st;
   endfunction

   // Lit segment of length seg_len+1 anchored at bit 0.
   function automatic logic [7:0] seg_mask(input logic [1:0] seg_len);
      logic [7:0] m;
      case (seg_len)
         2'd0:    m = 8'h01;
         2'd1:    m = 8'h03;
         2'd2:    m = 8'h07;
         2'd3:    m = 8'h0F;
         default: m = 8'h01;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/led_step_prescaler.sv
// Step-rate prescaler: fires tick once every div+1 enabled cycles.
module led_step_prescaler
   import led_ctrl_pkg::*;
#(
   parameter int CNT_W = 27
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic [CNT_W-1:0] div,
   output logic             tick
);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             tick_s;

   // Next count; a divider shrunk below the running count restarts without a tick.
   always_comb begin
      tick_s    = 1'b0;
      cnt_nxt_s = cnt_r;
      if (!en) begin
         cnt_nxt_s = '0;
      end else if (cnt_r > div) begin
         cnt_nxt_s = '0;
      end else if (cnt_r == div) begin
         cnt_nxt_s = '0;
         tick_s    = 1'b1;
      end else begin
         cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_nxt_s;
      end
   end

   assign tick = tick_s;

endmodule

// File: rtl/led_scan_ctrl.sv
// LED bar sequencer: OFF / SCAN / BLINK / STATIC modes plus req/ack override.
module led_scan_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int CNT_W    = 27,
   parameter int NUM_LEDS = 8
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                en_i,
   input  logic [CNT_W-1:0]    div_i,
   input  logic [1:0]          mode_i,
   input  logic [1:0]          seg_len_i,
   input  logic [7:0]          pat_i,
   input  logic                ovr_req_i,
   input  logic [7:0]          ovr_pat_i,
   output logic                ovr_ack_o,
   output logic [NUM_LEDS-1:0] led_o,
   output logic                step_o,
   output logic                dir_o
);

   logic       tick_s;
   state_t     state_r;
   state_t     state_nxt_s;
   state_t     target_s;
   logic [2:0] pos_r;
   logic [2:0] pos_nxt_s;
   logic [2:0] max_pos_s;
   logic       dir_r;
   logic       dir_nxt_s;
   logic       phase_r;
   logic       phase_nxt_s;
   logic [7:0] led_r;
   logic [7:0] led_nxt_s;
   logic       step_r;
   logic       step_nxt_s;
   logic       ack_r;
   logic       ack_nxt_s;

   led_step_prescaler #(.CNT_W(CNT_W)) u_prescaler (
      .clk  (clk),
      .rstn (rstn),
      .en   (en_i),
      .div  (div_i),
      .tick (tick_s)
   );

   assign target_s  = mode_to_state(mode_i);
   assign max_pos_s = 3'd7 - {1'b0, seg_len_i};

   // Next state; override beats mode change, which beats a pending tick.
   always_comb begin
      state_nxt_s = state_r;
      pos_nxt_s   = pos_r;
      dir_nxt_s   = dir_r;
      phase_nxt_s = phase_r;
      led_nxt_s   = led_r;
      step_nxt_s  = 1'b0;
      ack_nxt_s   = 1'b0;
      if (ovr_req_i) begin
         state_nxt_s = S_OVR;
         ack_nxt_s   = 1'b1;
         led_nxt_s   = ovr_pat_i;
      end else if (state_r != target_s) begin
         state_nxt_s = target_s;
         case (target_s)
            S_SCAN: begin
               pos_nxt_s = 3'd0;
               dir_nxt_s = 1'b0;
               led_nxt_s = seg_mask(seg_len_i);
            end
            S_BLINK: begin
               phase_nxt_s = 1'b1;
               led_nxt_s   = pat_i;
            end
            S_STATIC: led_nxt_s = pat_i;
            default:  led_nxt_s = 8'h00;
         endcase
      end else begin
         case (state_r)
            S_SCAN: begin
               // A longer segment can push the window past the top: pin it there heading down.
               if (pos_r > max_pos_s) begin
                  pos_nxt_s = max_pos_s;
                  dir_nxt_s = 1'b1;
               end else if (tick_s) begin
                  step_nxt_s = 1'b1;
                  if (!dir_r) begin
                     if (pos_r == max_pos_s) begin
                        dir_nxt_s = 1'b1;
                        pos_nxt_s = pos_r - 3'd1;
                     end else begin
                        pos_nxt_s = pos_r + 3'd1;
                     end
                  end else begin
                     if (pos_r == 3'd0) begin
                        dir_nxt_s = 1'b0;
                        pos_nxt_s = 3'd1;
                     end else begin
                        pos_nxt_s = pos_r - 3'd1;
                     end
                  end
               end else begin
                  pos_nxt_s = pos_r;
               end
               led_nxt_s = seg_mask(seg_len_i) << pos_nxt_s;
            end
            S_BLINK: begin
               if (tick_s) begin
                  step_nxt_s  = 1'b1;
                  phase_nxt_s = ~phase_r;
                  led_nxt_s   = phase_r ? 8'h00 : pat_i;
               end else begin
                  led_nxt_s = led_r;
               end
            end
            S_STATIC: led_nxt_s = pat_i;
            default: begin
               state_nxt_s = S_OFF;
               led_nxt_s   = 8'h00;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= S_OFF;
         pos_r   <= 3'd0;
         dir_r   <= 1'b0;
         phase_r <= 1'b1;
         led_r   <= 8'h00;
         step_r  <= 1'b0;
         ack_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         pos_r   <= pos_nxt_s;
         dir_r   <= dir_nxt_s;
         phase_r <= phase_nxt_s;
         led_r   <= led_nxt_s;
         step_r  <= step_nxt_s;
         ack_r   <= ack_nxt_s;
      end
   end

   assign led_o     = led_r;
   assign step_o    = step_r;
   assign dir_o     = dir_r;
   assign ovr_ack_o = ack_r;

endmodule
